// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded ID-side fields in, registered EX-side fields out.
// Counter outputs exist only when ID_EX_HAZARD_STATS_EN is defined.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              mem_stall_i;
  logic              flush_i;
  logic [DATA_W-1:0] pc_id_i;
  logic [DATA_W-1:0] rs1_data_id_i;
  logic [DATA_W-1:0] rs2_data_id_i;
  logic [DATA_W-1:0] imm_id_i;
  logic [9:0]        funct_id_i;
  logic [REG_AW-1:0] rs1_id_i;
  logic [REG_AW-1:0] rs2_id_i;
  logic [REG_AW-1:0] rd_id_i;
  logic [7:0]        ctrl_id_i;

  logic [DATA_W-1:0] pc_ex_o;
  logic [DATA_W-1:0] rs1_data_ex_o;
  logic [DATA_W-1:0] rs2_data_ex_o;
  logic [DATA_W-1:0] imm_ex_o;
  logic [9:0]        funct_ex_o;
  logic [REG_AW-1:0] rs1_ex_o;
  logic [REG_AW-1:0] rs2_ex_o;
  logic [REG_AW-1:0] rd_ex_o;
  logic [7:0]        ctrl_ex_o;
  logic              hold_o;
`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0]       bubble_cnt_o;
  logic [31:0]       stall_cnt_o;
`endif

  modport master (
    output mem_stall_i, flush_i, pc_id_i, rs1_data_id_i, rs2_data_id_i, imm_id_i,
           funct_id_i, rs1_id_i, rs2_id_i, rd_id_i, ctrl_id_i,
`ifdef ID_EX_HAZARD_STATS_EN
    input  bubble_cnt_o, stall_cnt_o,
`endif
    input  pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, funct_ex_o,
           rs1_ex_o, rs2_ex_o, rd_ex_o, ctrl_ex_o, hold_o
  );

  modport slave (
    input  mem_stall_i, flush_i, pc_id_i, rs1_data_id_i, rs2_data_id_i, imm_id_i,
           funct_id_i, rs1_id_i, rs2_id_i, rd_id_i, ctrl_id_i,
`ifdef ID_EX_HAZARD_STATS_EN
    output bubble_cnt_o, stall_cnt_o,
`endif
    output pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, funct_ex_o,
           rs1_ex_o, rs2_ex_o, rd_ex_o, ctrl_ex_o, hold_o
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and IF/ID hold.
// Optional bubble/stall counters are enabled by defining ID_EX_HAZARD_STATS_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic             clk_i,
  input logic             rst_i,
  id_ex_stage_reg_if.slave bus
);
  // ctrl layout: {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch}
  localparam int MEM_READ_BIT = 5;

  logic [DATA_W-1:0] pc_ex_r;
  logic [DATA_W-1:0] rs1_data_ex_r;
  logic [DATA_W-1:0] rs2_data_ex_r;
  logic [DATA_W-1:0] imm_ex_r;
  logic [9:0]        funct_ex_r;
  logic [REG_AW-1:0] rs1_ex_r;
  logic [REG_AW-1:0] rs2_ex_r;
  logic [REG_AW-1:0] rd_ex_r;
  logic [7:0]        ctrl_ex_r;

  logic              luh_s;
  logic              load_s;
  logic              bubble_s;
  logic              hold_s;
  logic [REG_AW-1:0] rd_nxt_s;
  logic [7:0]        ctrl_nxt_s;

  // Load-use hazard: EX is a load into a nonzero register that ID reads.
  always_comb begin
    luh_s = 1'b0;
    if (ctrl_ex_r[MEM_READ_BIT] && (rd_ex_r != {REG_AW{1'b0}}) &&
        ((rd_ex_r == bus.rs1_id_i) || (rd_ex_r == bus.rs2_id_i))) begin
      luh_s = 1'b1;
    end else begin
      luh_s = 1'b0;
    end
  end

  // Edge decision: stall freezes, flush or hazard turns the EX slot into a bubble.
  always_comb begin
    load_s     = 1'b1;
    bubble_s   = 1'b0;
    rd_nxt_s   = bus.rd_id_i;
    ctrl_nxt_s = bus.ctrl_id_i;
    if (bus.mem_stall_i) begin
      load_s = 1'b0;
    end else if (bus.flush_i || luh_s) begin
      bubble_s   = 1'b1;
      rd_nxt_s   = {REG_AW{1'b0}};
      ctrl_nxt_s = 8'h00;
    end else begin
      bubble_s = 1'b0;
    end
  end

  // Hold is forced low during reset even if the cache reports busy.
  always_comb begin
    hold_s = 1'b0;
    if (rst_i) begin
      hold_s = 1'b0;
    end else begin
      hold_s = bus.mem_stall_i | luh_s;
    end
  end

  // Pipeline register; reset state is a bubble (rd=0, ctrl=0).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_ex_r       <= {DATA_W{1'b0}};
      rs1_data_ex_r <= {DATA_W{1'b0}};
      rs2_data_ex_r <= {DATA_W{1'b0}};
      imm_ex_r      <= {DATA_W{1'b0}};
      funct_ex_r    <= 10'd0;
      rs1_ex_r      <= {REG_AW{1'b0}};
      rs2_ex_r      <= {REG_AW{1'b0}};
      rd_ex_r       <= {REG_AW{1'b0}};
      ctrl_ex_r     <= 8'h00;
    end else if (load_s) begin
      pc_ex_r       <= bus.pc_id_i;
      rs1_data_ex_r <= bus.rs1_data_id_i;
      rs2_data_ex_r <= bus.rs2_data_id_i;
      imm_ex_r      <= bus.imm_id_i;
      funct_ex_r    <= bus.funct_id_i;
      rs1_ex_r      <= bus.rs1_id_i;
      rs2_ex_r      <= bus.rs2_id_i;
      rd_ex_r       <= rd_nxt_s;
      ctrl_ex_r     <= ctrl_nxt_s;
    end else begin
      pc_ex_r       <= pc_ex_r;
      rs1_data_ex_r <= rs1_data_ex_r;
      rs2_data_ex_r <= rs2_data_ex_r;
      imm_ex_r      <= imm_ex_r;
      funct_ex_r    <= funct_ex_r;
      rs1_ex_r      <= rs1_ex_r;
      rs2_ex_r      <= rs2_ex_r;
      rd_ex_r       <= rd_ex_r;
      ctrl_ex_r     <= ctrl_ex_r;
    end
  end

  assign bus.pc_ex_o       = pc_ex_r;
  assign bus.rs1_data_ex_o = rs1_data_ex_r;
  assign bus.rs2_data_ex_o = rs2_data_ex_r;
  assign bus.imm_ex_o      = imm_ex_r;
  assign bus.funct_ex_o    = funct_ex_r;
  assign bus.rs1_ex_o      = rs1_ex_r;
  assign bus.rs2_ex_o      = rs2_ex_r;
  assign bus.rd_ex_o       = rd_ex_r;
  assign bus.ctrl_ex_o     = ctrl_ex_r;
  assign bus.hold_o        = hold_s;

`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] stall_cnt_r;

  // Free-running event counters; natural 32-bit wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
    end else begin
      if (bubble_s) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
      if (bus.mem_stall_i) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.bubble_cnt_o = bubble_cnt_r;
  assign bus.stall_cnt_o  = stall_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized self-checking bench for id_ex_stage_reg against a field-level
// reference model of the EX slot; directed cases precede the random run.
module tb_id_ex_stage_reg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } instr_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  instr_t      id;
  instr_t      ex;
  logic        flush_v;
  logic        stall_v;
  logic [31:0] exp_bub;
  logic [31:0] exp_stall;

  id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.mem_stall_i   = stall_v;
    bus.flush_i       = flush_v;
    bus.pc_id_i       = id.pc;
    bus.rs1_data_id_i = id.d1;
    bus.rs2_data_id_i = id.d2;
    bus.imm_id_i      = id.imm;
    bus.funct_id_i    = id.funct;
    bus.rs1_id_i      = id.rs1;
    bus.rs2_id_i      = id.rs2;
    bus.rd_id_i       = id.rd;
    bus.ctrl_id_i     = id.ctrl;
  endtask

  // A load in EX whose nonzero destination is read by the instruction in ID.
  function automatic logic model_luh();
    return ex.ctrl[5] && (ex.rd != 5'd0) && ((ex.rd == id.rs1) || (ex.rd == id.rs2));
  endfunction

  function automatic logic model_hold();
    return !rst && (stall_v || model_luh());
  endfunction

  task automatic model_reset();
    ex        = '0;
    exp_bub   = 32'd0;
    exp_stall = 32'd0;
  endtask

  task automatic model_edge();
    instr_t nxt;
    if (rst) begin
      model_reset();
    end else if (stall_v) begin
      exp_stall = exp_stall + 32'd1;
    end else begin
      nxt = id;
      if (flush_v || model_luh()) begin
        nxt.ctrl = 8'h00;
        nxt.rd   = 5'd0;
        exp_bub  = exp_bub + 32'd1;
      end
      ex = nxt;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_pc"},    bus.pc_ex_o,       ex.pc);
    check_val({tag, "_d1"},    bus.rs1_data_ex_o, ex.d1);
    check_val({tag, "_d2"},    bus.rs2_data_ex_o, ex.d2);
    check_val({tag, "_imm"},   bus.imm_ex_o,      ex.imm);
    check_val({tag, "_funct"}, {22'd0, bus.funct_ex_o}, {22'd0, ex.funct});
    check_val({tag, "_rs1"},   {27'd0, bus.rs1_ex_o},   {27'd0, ex.rs1});
    check_val({tag, "_rs2"},   {27'd0, bus.rs2_ex_o},   {27'd0, ex.rs2});
    check_val({tag, "_rd"},    {27'd0, bus.rd_ex_o},    {27'd0, ex.rd});
    check_val({tag, "_ctrl"},  {24'd0, bus.ctrl_ex_o},  {24'd0, ex.ctrl});
`ifdef ID_EX_HAZARD_STATS_EN
    check_val({tag, "_bubcnt"},   bus.bubble_cnt_o, exp_bub);
    check_val({tag, "_stallcnt"}, bus.stall_cnt_o,  exp_stall);
`endif
  endtask

  // Called during the low phase: check hold, take one edge, check EX slot.
  task automatic tick(input string tag);
    drive();
    #1;
    check_val({tag, "_hold"}, {31'd0, bus.hold_o}, {31'd0, model_hold()});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [7:0] ctrl);
    instr_t t;
    t.pc    = pc;
    t.d1    = $urandom;
    t.d2    = $urandom;
    t.imm   = $urandom;
    t.funct = 10'($urandom);
    t.rs1   = rs1;
    t.rs2   = rs2;
    t.rd    = rd;
    t.ctrl  = ctrl;
    return t;
  endfunction

  initial begin
    logic held;
    n_checks = 0;
    n_fail   = 0;
    stall_v  = 1'b0;
    flush_v  = 1'b0;
    id       = mk(32'h0000_0010, 5'd1, 5'd2, 5'd3, 8'h82);
    model_reset();
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("rst");
    rst = 1'b0;

    // Normal flow
    id = mk(32'h0000_0040, 5'd1, 5'd2, 5'd5, 8'hA2);
    tick("flow");
    check_val("flow_rd_lit",   {27'd0, bus.rd_ex_o},  32'd5);
    check_val("flow_ctrl_lit", {24'd0, bus.ctrl_ex_o}, 32'hA2);
    check_val("flow_pc_lit",   bus.pc_ex_o,            32'h40);

    // Mid-cycle reset with busy cache, then release while still stalled
    stall_v = 1'b1;
    drive();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    check_val("arst_hold", {31'd0, bus.hold_o}, 32'd0);
    rst = 1'b0;
    id = mk(32'h0000_0044, 5'd1, 5'd2, 5'd4, 8'h82);
    tick("rst_stall");
    stall_v = 1'b0;

    // Load-use: load to x7, consumer reads x7 on rs2
    id = mk(32'h0000_0050, 5'd1, 5'd2, 5'd7, 8'h64);
    tick("ld");
    id = mk(32'h0000_0054, 5'd3, 5'd7, 5'd9, 8'h82);
    drive();
    #1;
    check_val("lu_hold_lit", {31'd0, bus.hold_o}, 32'd1);
    tick("lu_bubble");
    check_val("lu_ctrl_lit", {24'd0, bus.ctrl_ex_o}, 32'd0);
    check_val("lu_rd_lit",   {27'd0, bus.rd_ex_o},  32'd0);
    tick("lu_reload");
    check_val("lu_reload_rd", {27'd0, bus.rd_ex_o}, 32'd9);

    // Load to x0 never creates a hazard
    id = mk(32'h0000_0060, 5'd1, 5'd2, 5'd0, 8'h24);
    tick("ld_x0");
    id = mk(32'h0000_0064, 5'd0, 5'd4, 5'd6, 8'h82);
    drive();
    #1;
    check_val("x0_hold_lit", {31'd0, bus.hold_o}, 32'd0);
    tick("x0_use");
    check_val("x0_rd_lit", {27'd0, bus.rd_ex_o}, 32'd6);

    // Stall outranks flush and load-use
    id = mk(32'h0000_0070, 5'd1, 5'd2, 5'd7, 8'h64);
    tick("ld2");
    id = mk(32'h0000_0074, 5'd7, 5'd3, 5'd8, 8'h82);
    stall_v = 1'b1;
    flush_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check_val("stall_rd_lit", {27'd0, bus.rd_ex_o}, 32'd7);
    end
    stall_v = 1'b0;
    tick("flush1");
    check_val("flush_ctrl_lit", {24'd0, bus.ctrl_ex_o}, 32'd0);
    id = mk(32'h0000_0080, 5'd1, 5'd2, 5'd3, 8'h82);
    tick("flush2");
    flush_v = 1'b0;
`ifdef ID_EX_HAZARD_STATS_EN
    check_val("stats_bub_lit",   bus.bubble_cnt_o, 32'd3);
    check_val("stats_stall_lit", bus.stall_cnt_o,  32'd4);
    dut.bubble_cnt_r = 32'hFFFF_FFFF;
    exp_bub          = 32'hFFFF_FFFF;
    flush_v = 1'b1;
    tick("wrap");
    check_val("wrap_lit", bus.bubble_cnt_o, 32'd0);
    flush_v = 1'b0;
`endif

    // Random run with a well-behaved upstream: hold re-presents ID, flush persists through stall
    held = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        id = mk($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 8'($urandom));
      end
      if (!(stall_v && flush_v)) flush_v = ($urandom_range(0, 6) == 0);
      stall_v = ($urandom_range(0, 4) == 0);
      if (n % 97 == 96) begin
        rst = 1'b1;
        tick("rnd_rst");
        rst = 1'b0;
        held = 1'b0;
      end else begin
        drive();
        #1;
        held = model_hold();
        tick("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, directly upstream of the EX-stage forwarding unit.
- Captures decoded control, operands, immediate and register addresses each cycle.
- Supplies EX-stage rs1/rs2/rd and control to the forwarding unit and ALU.
- Freezes on data-cache stall, inserts bubbles on branch flush or load-use hazard, and tells IF/ID to hold.

Parameters:
- DATA_W, 32, width of pc, operand and immediate fields
- REG_AW, 5, register address width

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- mem_stall_i  input  1  data-cache busy; freeze the whole register
- flush_i  input  1  branch taken; next EX content is a bubble
- pc_id_i  input  DATA_W  PC of the ID instruction
- rs1_data_id_i  input  DATA_W  register file read data 1
- rs2_data_id_i  input  DATA_W  register file read data 2
- imm_id_i  input  DATA_W  sign-extended immediate
- funct_id_i  input  10  funct7 and funct3
- rs1_id_i  input  REG_AW  source register 1 address
- rs2_id_i  input  REG_AW  source register 2 address
- rd_id_i  input  REG_AW  destination register address
- ctrl_id_i  input  8  {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch}
- pc_ex_o  output  DATA_W  registered PC
- rs1_data_ex_o  output  DATA_W  registered read data 1
- rs2_data_ex_o  output  DATA_W  registered read data 2
- imm_ex_o  output  DATA_W  registered immediate
- funct_ex_o  output  10  registered funct
- rs1_ex_o  output  REG_AW  registered rs1 address, to forwarding unit
- rs2_ex_o  output  REG_AW  registered rs2 address, to forwarding unit
- rd_ex_o  output  REG_AW  registered rd address
- ctrl_ex_o  output  8  registered control
- hold_o  output  1  combinational; PC and IF/ID must not update this cycle

Behaviour:
- Reset (asynchronous, rst_i=1): every registered output goes to 0 immediately. rd_ex_o=0 and ctrl_ex_o=0 make the reset state a bubble.
- hold_o while in reset: 0.
- Load-use detect (combinational):
  - luh = ctrl_ex_o[MemRead] & (rd_ex_o != 0) & ((rd_ex_o == rs1_id_i) | (rd_ex_o == rs2_id_i)).
  - Registers compared by exact 5-bit equality.
- hold_o = mem_stall_i | luh.
- Per-edge priority, highest first:
  1. mem_stall_i=1: all registers keep their value. flush_i and luh are ignored this edge; upstream holds flush_i until the stall clears.
  2. flush_i=1: ctrl_ex_o<=0 and rd_ex_o<=0 (bubble). Data, pc, imm and rs fields load normally (don't-care).
  3. luh=1: ctrl_ex_o<=0 and rd_ex_o<=0 (bubble). The ID instruction is re-presented next cycle because hold_o=1.
  4. Otherwise: load all fields from the ID inputs.
- Latency: one cycle, ID to EX.
- A bubble never re-triggers luh, because its MemRead=0.
- Back-to-back loads with a dependent third instruction: exactly one bubble per load-use pair.
- Reset deasserting mid-stall: the first clean edge follows the priority above with the register in bubble state.
- No internal FSM beyond the bubble/hold decision. The hazard condition is a function of registered EX state and current ID inputs.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- When defined, adds two outputs, both 32-bit, reset to 0, wrapping at 2^32-1 to 0:
  - bubble_cnt_o (32): increments on every edge where case 2 or case 3 applies.
  - stall_cnt_o (32): increments on every edge with mem_stall_i=1.
- When undefined, the ports and counters are absent and there is no behavioural change.

Test Plan:
- Reset: assert rst_i mid-cycle with non-zero outputs -> all outputs 0 before the next edge; hold_o=0.
- Normal flow: ID rd=5, ctrl=8'hA2, pc=0x40 -> next edge rd_ex_o=5, ctrl_ex_o=8'hA2, pc_ex_o=0x40.
- Load-use: EX holds MemRead=1, rd=7; ID rs2=7 -> hold_o=1 and next edge ctrl_ex_o=0, rd_ex_o=0. Following edge loads the held instruction.
- Load to x0: EX MemRead=1, rd=0; ID rs1=0 -> hold_o=0 and no bubble.
- Stall priority: mem_stall_i=1 with flush_i=1 and luh=1 for 3 cycles -> outputs unchanged all 3 edges. After release with flush_i=1 -> bubble on the first edge.
- Stats (macro on): 2 flush edges, 1 load-use, 4 stall cycles -> bubble_cnt_o=3, stall_cnt_o=4. Preload 32'hFFFF_FFFF and add one bubble -> wraps to 0.
